// File: rtl/alu_host_framer_if.sv
// Bundle of the command, operand, UART stream and response channels of
// alu_host_framer. The framer connects through the slave modport; the host
// or bench driving commands uses the master modport.
interface alu_host_framer_if #(
  parameter int MAX_OPERANDS_P = 4
);
  localparam int CW = $clog2(MAX_OPERANDS_P + 1);

  logic          cmd_valid_i;
  logic          cmd_ready_o;
  logic [7:0]    cmd_opcode_i;
  logic [CW-1:0] cmd_count_i;

  logic          opnd_valid_i;
  logic          opnd_ready_o;
  logic [31:0]   opnd_data_i;

  logic [7:0]    tx_tdata_o;
  logic          tx_tvalid_o;
  logic          tx_tready_i;

  logic [7:0]    rx_tdata_i;
  logic          rx_tvalid_i;
  logic          rx_tready_o;

  logic          rsp_valid_o;
  logic          rsp_ready_i;
  logic [31:0]   rsp_data_o;
  logic          rsp_error_o;

  logic          busy_o;

  modport slave (
    input  cmd_valid_i, cmd_opcode_i, cmd_count_i,
    input  opnd_valid_i, opnd_data_i,
    input  tx_tready_i,
    input  rx_tdata_i, rx_tvalid_i,
    input  rsp_ready_i,
    output cmd_ready_o, opnd_ready_o,
    output tx_tdata_o, tx_tvalid_o,
    output rx_tready_o,
    output rsp_valid_o, rsp_data_o, rsp_error_o,
    output busy_o
  );

  modport master (
    output cmd_valid_i, cmd_opcode_i, cmd_count_i,
    output opnd_valid_i, opnd_data_i,
    output tx_tready_i,
    output rx_tdata_i, rx_tvalid_i,
    output rsp_ready_i,
    input  cmd_ready_o, opnd_ready_o,
    input  tx_tdata_o, tx_tvalid_o,
    input  rx_tready_o,
    input  rsp_valid_o, rsp_data_o, rsp_error_o,
    input  busy_o
  );
endinterface

// File: rtl/alu_host_framer.sv
// Host-side command framer for the UART ALU link.
// Serialises opcode, 0x00, 16-bit little-endian length and operand words
// (LSB byte first) onto the UART tx stream, then collects a 4-byte
// little-endian result from the rx stream.
// Optional feature: define ALU_HOST_TIMEOUT_EN to bound the response wait
// to TIMEOUT_CYCLES_P clocks (error response with partial data on expiry).
//
// state      | meaning
// -----------+-----------------------------------------------------------
// S_IDLE     | ready for a command; stray rx bytes are dropped
// S_HDR      | sending the 4 header bytes
// S_OPND     | taking operand words and sending each as 4 bytes
// S_WAIT_RSP | collecting the 4 result bytes from rx
// S_DONE     | result/error presented until the host takes it
module alu_host_framer #(
  parameter int MAX_OPERANDS_P   = 4,
  parameter int TIMEOUT_CYCLES_P = 1000000
) (
  input  logic               clk,
  input  logic               rst_n,
  alu_host_framer_if.slave   bus
);

  localparam int            CW      = $clog2(MAX_OPERANDS_P + 1);
  localparam logic [CW-1:0] MAX_CNT = CW'(MAX_OPERANDS_P);

  if (MAX_OPERANDS_P < 1 || TIMEOUT_CYCLES_P < 1) begin : g_param_check
    $error("alu_host_framer: MAX_OPERANDS_P and TIMEOUT_CYCLES_P must be >= 1");
  end

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_HDR      = 3'd1,
    S_OPND     = 3'd2,
    S_WAIT_RSP = 3'd3,
    S_DONE     = 3'd4
  } state_t;

  state_t        state;
  state_t        state_nxt;

  logic [7:0]    opcode_q;
  logic [CW-1:0] count_q;
  logic [CW-1:0] opnd_idx;
  logic [1:0]    hdr_idx;
  logic [1:0]    beat_idx;
  logic [1:0]    rx_cnt;
  logic [31:0]   word_q;
  logic          word_held;
  logic [31:0]   rsp_data_q;
  logic          rsp_err_q;
  logic [15:0]   pkt_len;

  logic          cmd_ready;
  logic          opnd_ready;
  logic          tx_valid;
  logic [7:0]    tx_data;
  logic          rx_ready;

  logic          cmd_fire;
  logic          cmd_ok;
  logic          opcode_ok;
  logic          opnd_fire;
  logic          tx_fire;
  logic          rx_fire;
  logic          last_beat;
  logic          tmo_hit;

  assign cmd_fire  = bus.cmd_valid_i & cmd_ready;
  assign opnd_fire = bus.opnd_valid_i & opnd_ready;
  assign tx_fire   = tx_valid & bus.tx_tready_i;
  assign rx_fire   = bus.rx_tvalid_i & rx_ready;

  assign opcode_ok = (bus.cmd_opcode_i == 8'hA8) ||
                     (bus.cmd_opcode_i == 8'hAD) ||
                     (bus.cmd_opcode_i == 8'hAE);
  assign cmd_ok    = opcode_ok && (bus.cmd_count_i != '0) &&
                     (bus.cmd_count_i <= MAX_CNT);

  // 4 bytes of header plus 4 bytes per operand; cannot wrap for any sane MAX
  assign pkt_len   = 16'd4 + (16'(count_q) << 2);

  assign last_beat = (beat_idx == 2'd3) && (opnd_idx == (count_q - CW'(1)));

`ifdef ALU_HOST_TIMEOUT_EN
  localparam logic [31:0] TMO_LAST = 32'(TIMEOUT_CYCLES_P - 1);

  logic [31:0] tmo_cnt;

  // Response watchdog: reloads outside WAIT_RSP and on every rx byte, so it
  // only expires after TIMEOUT_CYCLES_P consecutive silent cycles.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tmo_cnt <= TMO_LAST;
    end else if (state != S_WAIT_RSP || rx_fire) begin
      tmo_cnt <= TMO_LAST;
    end else if (tmo_cnt != 32'd0) begin
      tmo_cnt <= tmo_cnt - 32'd1;
    end
  end

  assign tmo_hit = (state == S_WAIT_RSP) && !rx_fire && (tmo_cnt == 32'd0);
`else
  assign tmo_hit = 1'b0;
`endif

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nxt;
  end

  // Next-state decode
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:     if (cmd_fire) state_nxt = cmd_ok ? S_HDR : S_DONE;
      S_HDR:      if (tx_fire && hdr_idx == 2'd3) state_nxt = S_OPND;
      S_OPND:     if (tx_fire && last_beat) state_nxt = S_WAIT_RSP;
      S_WAIT_RSP: begin
        if (rx_fire && rx_cnt == 2'd3) state_nxt = S_DONE;
        else if (tmo_hit)              state_nxt = S_DONE;
      end
      S_DONE:     if (bus.rsp_ready_i) state_nxt = S_IDLE;
      default:    state_nxt = S_IDLE;
    endcase
  end

  // Outputs decoded from state; tx_valid follows state so an async reset
  // drops it immediately.
  always_comb begin
    cmd_ready  = (state == S_IDLE);
    opnd_ready = (state == S_OPND) && !word_held;
    tx_valid   = (state == S_HDR) || ((state == S_OPND) && word_held);
    rx_ready   = (state != S_DONE);
    tx_data    = 8'h00;
    if (state == S_HDR) begin
      case (hdr_idx)
        2'd0:    tx_data = opcode_q;
        2'd1:    tx_data = 8'h00;
        2'd2:    tx_data = pkt_len[7:0];
        default: tx_data = pkt_len[15:8];
      endcase
    end else if (state == S_OPND) begin
      tx_data = word_q[{beat_idx, 3'b000} +: 8];
    end
  end

  assign bus.cmd_ready_o  = cmd_ready;
  assign bus.opnd_ready_o = opnd_ready;
  assign bus.tx_tvalid_o  = tx_valid;
  assign bus.tx_tdata_o   = tx_data;
  assign bus.rx_tready_o  = rx_ready;
  assign bus.rsp_valid_o  = (state == S_DONE);
  assign bus.rsp_data_o   = rsp_data_q;
  assign bus.rsp_error_o  = rsp_err_q;
  assign bus.busy_o       = (state != S_IDLE);

  // Datapath: command latch, byte indices, held operand word, result assembly
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      opcode_q   <= 8'h00;
      count_q    <= '0;
      opnd_idx   <= '0;
      hdr_idx    <= 2'd0;
      beat_idx   <= 2'd0;
      rx_cnt     <= 2'd0;
      word_q     <= 32'd0;
      word_held  <= 1'b0;
      rsp_data_q <= 32'd0;
      rsp_err_q  <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (cmd_fire) begin
            opcode_q   <= bus.cmd_opcode_i;
            count_q    <= bus.cmd_count_i;
            opnd_idx   <= '0;
            hdr_idx    <= 2'd0;
            beat_idx   <= 2'd0;
            rx_cnt     <= 2'd0;
            word_held  <= 1'b0;
            rsp_data_q <= 32'd0;
            rsp_err_q  <= !cmd_ok;
          end
        end
        S_HDR: begin
          if (tx_fire) hdr_idx <= hdr_idx + 2'd1;
        end
        S_OPND: begin
          if (opnd_fire) begin
            word_q    <= bus.opnd_data_i;
            word_held <= 1'b1;
            beat_idx  <= 2'd0;
          end else if (tx_fire) begin
            beat_idx <= beat_idx + 2'd1;
            if (beat_idx == 2'd3) begin
              word_held <= 1'b0;
              opnd_idx  <= opnd_idx + CW'(1);
            end
            if (last_beat) rx_cnt <= 2'd0;
          end
        end
        S_WAIT_RSP: begin
          if (rx_fire) begin
            rsp_data_q[{rx_cnt, 3'b000} +: 8] <= bus.rx_tdata_i;
            rx_cnt <= rx_cnt + 2'd1;
            if (rx_cnt == 2'd3) rsp_err_q <= 1'b0;
          end else if (tmo_hit) begin
            rsp_err_q <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
